multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle controller for the RISC-V SiMPLE core, the parametrised successor to the single-cycle controller. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and waits on ready handshakes from instruction and data memories with variable latency. It stalls on an optional multi-cycle M-extension ALU, and traps on illegal opcodes or memory timeouts. It drives the same datapath select signals as the single-cycle controller, plus the fetch and instruction-register controls.

## Interface
- `MEM_TIMEOUT`, 16: maximum wait cycles for a memory ready; 0 disables the timeout.
- `ENABLE_MULDIV`, 1: when 1, EXECUTE waits for `alu_done` on M-extension ops; when 0, M ops are illegal.
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `inst_opcode` in 7: opcode from the instruction register.
- `inst_funct7` in 7: funct7 from the instruction register; `0000001` with OP marks an M op.
- `take_branch` in 1: branch comparison result.
- `inst_mem_ready` in 1: instruction memory data is valid this cycle.
- `data_mem_ready` in 1: data memory access completes this cycle.
- `alu_done` in 1: multi-cycle ALU result is valid.
- `inst_mem_read_enable` out 1: fetch request.
- `ir_write_enable` out 1: latch the fetched instruction.
- `pc_write_enable` out 1: commit the next PC.
- `regfile_write_enable` out 1: register file write.
- `alu_operand_a_select` out 1: ALU operand A select.
- `alu_operand_b_select` out 1: ALU operand B select.
- `alu_op_type` out 2: ALU operation class.
- `alu_start` out 1: one-cycle start pulse to the multi-cycle ALU.
- `data_mem_read_enable` out 1: data memory read request.
- `data_mem_write_enable` out 1: data memory write request.
- `reg_writeback_select` out 3: writeback source.
- `next_pc_select` out 2: next-PC source.
- `inst_retired` out 1: one-cycle pulse per committed instruction.
- `illegal_inst` out 1: sticky flag.
- `bus_error` out 1: sticky flag.
- `halted` out 1: controller is in TRAP.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- FETCH:
  - `inst_mem_read_enable`=1 until `inst_mem_ready`.
  - In the ready cycle, `ir_write_enable`=1 and the next state is DECODE.
- DECODE (1 cycle):
  - Opcodes outside {LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL} go to TRAP with `illegal_inst` set.
  - An M op with `ENABLE_MULDIV`=0 also goes to TRAP with `illegal_inst` set.
  - All other opcodes go to EXECUTE.
- EXECUTE:
  - Selects and `alu_op_type` are driven per opcode, identical to the single-cycle mapping: LOAD/STORE/AUIPC/JAL/JALR=ADD, OP_IMM=OP_IMM, OP=OP, BRANCH=BRANCH.
  - For an M op, `alu_start` pulses on the first EXECUTE cycle, and the state holds until `alu_done`.
  - Exit routing:
    - LOAD/STORE go to MEM.
    - BRANCH and MISC_MEM commit in the exit cycle (`pc_write_enable`, `inst_retired`), then go to FETCH.
    - All others go to WRITEBACK.
- MEM:
  - Read or write enable is held until `data_mem_ready`.
  - LOAD then goes to WRITEBACK.
  - STORE commits in the ready cycle, then goes to FETCH.
- WRITEBACK (1 cycle):
  - `regfile_write_enable`=1, `pc_write_enable`=1, `inst_retired`=1, then FETCH.
  - `reg_writeback_select`: LOAD=DATA, LUI=IMM, JAL/JALR=PC4, otherwise ALU.
- `next_pc_select`: BRANCH gives `take_branch` ? PC_IMM : PC4; JALR gives RS1_IMM; JAL gives PC_IMM; otherwise PC4. It is meaningful only when `pc_write_enable`=1.
- Don't-care outputs are driven to 0, never x.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments on each cycle without ready.
  - When `MEM_TIMEOUT`>0 and the count reaches `MEM_TIMEOUT` with ready low, the next state is TRAP with `bus_error` set.
  - Ready arriving in the same cycle the count reaches `MEM_TIMEOUT` wins; no trap.
- TRAP:
  - Absorbing state. All enables are 0 and `halted`=1.
  - Only `reset_n` exits it.

## Timing
- Reset:
  - State=FETCH, counter=0, flags=0.
  - All outputs 0 except `inst_mem_read_enable`=1.
  - Reset takes effect immediately and asynchronously, including mid-handshake; the in-flight access is abandoned.
- Latency with zero-wait memories (ready in the request cycle):
  - BRANCH/FENCE: 3 cycles.
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle or `alu_done` wait cycle adds 1.
- `inst_retired` is asserted exactly in the cycle of `pc_write_enable`, once per instruction.
- Ready inputs are ignored outside their own wait state.

## Structure
- Package `riscv_ctl_pkg`:
  - `OPCODE_*` constants (standard RV32I values).
  - CTL encodings:
    - PC4=0, PC_IMM=1, RS1_IMM=2.
    - ALU_A_RS1=0, ALU_A_PC=1.
    - ALU_B_RS2=0, ALU_B_IMM=1.
    - ALU_ADD=0, ALU_OP=1, ALU_OP_IMM=2, ALU_BRANCH=3.
    - WRITEBACK_ALU=0, DATA=1, IMM=2, PC4=3.
  - `ctl_state_t` enum.
- Sub-module `mem_wait_timer`:
  - Inputs: clear, count enable, `MEM_TIMEOUT`.
  - Output: `expired`.
  - Counter width is $clog2(MEM_TIMEOUT+1).

## Test plan
- ADD (OP, funct7=0): both memories ready immediately -> states FETCH, DECODE, EXECUTE, WRITEBACK; `regfile_write_enable` and `inst_retired` high in cycle 4 only.
- LOAD with `data_mem_ready` delayed 3 cycles -> `data_mem_read_enable` high for 4 cycles; WRITEBACK select=1; total 8 cycles.
- BRANCH with `take_branch`=1 -> `pc_write_enable` in cycle 3 with `next_pc_select`=1; `regfile_write_enable` never asserted.
- `MEM_TIMEOUT`=4, `inst_mem_ready` held low -> TRAP after 4 wait cycles; `bus_error`=1, `halted`=1; all enables 0 thereafter. A repeat run with ready on wait cycle 4 gives no trap.
- Opcode 7'b0000000 -> TRAP after DECODE with `illegal_inst`=1. An M op with `ENABLE_MULDIV`=0 -> same result; with `ENABLE_MULDIV`=1 and `alu_done` after 5 cycles -> `alu_start` pulses once and WRITEBACK follows the `alu_done` cycle.
- `reset_n` low during a MEM wait -> outputs at reset values immediately; after release, the controller resumes at FETCH.

Source files
------------

// File: rtl/riscv_ctl_pkg.sv
// Shared encodings for the SiMPLE controllers: RV32I opcodes, datapath select
// values and the multi-cycle controller state type.
package riscv_ctl_pkg;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;

  localparam logic [6:0] FUNCT7_MULDIV   = 7'b0000001;

  localparam logic [1:0] NEXT_PC_PC4     = 2'd0;
  localparam logic [1:0] NEXT_PC_PC_IMM  = 2'd1;
  localparam logic [1:0] NEXT_PC_RS1_IMM = 2'd2;

  localparam logic ALU_A_RS1 = 1'b0;
  localparam logic ALU_A_PC  = 1'b1;
  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP     = 2'd1;
  localparam logic [1:0] ALU_OP_IMM = 2'd2;
  localparam logic [1:0] ALU_BRANCH = 2'd3;

  localparam logic [2:0] WRITEBACK_ALU  = 3'd0;
  localparam logic [2:0] WRITEBACK_DATA = 3'd1;
  localparam logic [2:0] WRITEBACK_IMM  = 3'd2;
  localparam logic [2:0] WRITEBACK_PC4  = 3'd3;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } ctl_state_t;

  function automatic logic is_legal_opcode(input logic [6:0] opcode);
    case (opcode)
      OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_AUIPC, OPCODE_STORE,
      OPCODE_OP, OPCODE_LUI, OPCODE_BRANCH, OPCODE_JALR, OPCODE_JAL:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles since the last clear and flags when the
// configured limit is reached; a limit of 0 never expires.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturate at the limit so a long stall cannot wrap back below it.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle SiMPLE controller: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// waits on memory and M-extension ALU handshakes, and traps on faults.
module multicycle_control
  import riscv_ctl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter int unsigned ENABLE_MULDIV = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] inst_opcode,
  input  logic [6:0] inst_funct7,
  input  logic       take_branch,
  input  logic       inst_mem_ready,
  input  logic       data_mem_ready,
  input  logic       alu_done,
  output logic       inst_mem_read_enable,
  output logic       ir_write_enable,
  output logic       pc_write_enable,
  output logic       regfile_write_enable,
  output logic       alu_operand_a_select,
  output logic       alu_operand_b_select,
  output logic [1:0] alu_op_type,
  output logic       alu_start,
  output logic       data_mem_read_enable,
  output logic       data_mem_write_enable,
  output logic [2:0] reg_writeback_select,
  output logic [1:0] next_pc_select,
  output logic       inst_retired,
  output logic       illegal_inst,
  output logic       bus_error,
  output logic       halted
);

  localparam logic MULDIV_ON = (ENABLE_MULDIV != 0);

  ctl_state_t state_q, state_d;
  logic illegal_q, illegal_d;
  logic bus_error_q, bus_error_d;
  logic alu_busy_q, alu_busy_d;

  logic timer_clear;
  logic timer_count_en;
  logic timer_expired;
  logic is_m_op;
  logic m_wait;

  assign is_m_op = (inst_opcode == OPCODE_OP) && (inst_funct7 == FUNCT7_MULDIV);
  assign m_wait  = MULDIV_ON && is_m_op;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .count_en(timer_count_en),
    .expired (timer_expired)
  );

  // The counter restarts whenever a fresh memory wait state is entered.
  assign timer_clear = (state_d != state_q) &&
                       ((state_d == ST_FETCH) || (state_d == ST_MEM));

  always_comb begin
    state_d               = state_q;
    illegal_d             = illegal_q;
    bus_error_d           = bus_error_q;
    alu_busy_d            = 1'b0;
    timer_count_en        = 1'b0;
    inst_mem_read_enable  = 1'b0;
    ir_write_enable       = 1'b0;
    pc_write_enable       = 1'b0;
    regfile_write_enable  = 1'b0;
    alu_operand_a_select  = ALU_A_RS1;
    alu_operand_b_select  = ALU_B_RS2;
    alu_op_type           = ALU_ADD;
    alu_start             = 1'b0;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    reg_writeback_select  = WRITEBACK_ALU;
    next_pc_select        = NEXT_PC_PC4;
    inst_retired          = 1'b0;

    case (state_q)
      ST_FETCH: begin
        inst_mem_read_enable = 1'b1;
        if (inst_mem_ready) begin
          ir_write_enable = 1'b1;
          state_d         = ST_DECODE;
        end else begin
          timer_count_en = 1'b1;
          if (timer_expired) begin
            state_d     = ST_TRAP;
            bus_error_d = 1'b1;
          end
        end
      end

      ST_DECODE: begin
        if (!is_legal_opcode(inst_opcode) || (is_m_op && !MULDIV_ON)) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        case (inst_opcode)
          OPCODE_LOAD, OPCODE_STORE, OPCODE_JALR: begin
            alu_operand_b_select = ALU_B_IMM;
          end
          OPCODE_AUIPC, OPCODE_JAL: begin
            alu_operand_a_select = ALU_A_PC;
            alu_operand_b_select = ALU_B_IMM;
          end
          OPCODE_OP_IMM: begin
            alu_operand_b_select = ALU_B_IMM;
            alu_op_type          = ALU_OP_IMM;
          end
          OPCODE_OP:     alu_op_type = ALU_OP;
          OPCODE_BRANCH: alu_op_type = ALU_BRANCH;
          default: ;
        endcase

        // alu_busy_q marks the cycles after the start pulse of an M op.
        alu_start = m_wait && !alu_busy_q;
        if (m_wait && !alu_done) begin
          alu_busy_d = 1'b1;
        end else if ((inst_opcode == OPCODE_LOAD) || (inst_opcode == OPCODE_STORE)) begin
          state_d = ST_MEM;
        end else if ((inst_opcode == OPCODE_BRANCH) || (inst_opcode == OPCODE_MISC_MEM)) begin
          pc_write_enable = 1'b1;
          inst_retired    = 1'b1;
          state_d         = ST_FETCH;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end

      ST_MEM: begin
        if (inst_opcode == OPCODE_LOAD) begin
          data_mem_read_enable = 1'b1;
        end else begin
          data_mem_write_enable = 1'b1;
        end
        if (data_mem_ready) begin
          if (inst_opcode == OPCODE_LOAD) begin
            state_d = ST_WRITEBACK;
          end else begin
            pc_write_enable = 1'b1;
            inst_retired    = 1'b1;
            state_d         = ST_FETCH;
          end
        end else begin
          timer_count_en = 1'b1;
          if (timer_expired) begin
            state_d     = ST_TRAP;
            bus_error_d = 1'b1;
          end
        end
      end

      ST_WRITEBACK: begin
        regfile_write_enable = 1'b1;
        pc_write_enable      = 1'b1;
        inst_retired         = 1'b1;
        state_d              = ST_FETCH;
        case (inst_opcode)
          OPCODE_LOAD:             reg_writeback_select = WRITEBACK_DATA;
          OPCODE_LUI:              reg_writeback_select = WRITEBACK_IMM;
          OPCODE_JAL, OPCODE_JALR: reg_writeback_select = WRITEBACK_PC4;
          default:                 reg_writeback_select = WRITEBACK_ALU;
        endcase
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_TRAP;
    endcase

    if (pc_write_enable) begin
      case (inst_opcode)
        OPCODE_BRANCH: next_pc_select = take_branch ? NEXT_PC_PC_IMM : NEXT_PC_PC4;
        OPCODE_JALR:   next_pc_select = NEXT_PC_RS1_IMM;
        OPCODE_JAL:    next_pc_select = NEXT_PC_PC_IMM;
        default:       next_pc_select = NEXT_PC_PC4;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FETCH;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      alu_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
      alu_busy_q  <= alu_busy_d;
    end
  end

  assign illegal_inst = illegal_q;
  assign bus_error    = bus_error_q;
  assign halted       = (state_q == ST_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors for
// each instruction class, memory/ALU waits, timeouts, traps and async reset.
module tb_multicycle_control;
  import riscv_ctl_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] inst_opcode = '0;
  logic [6:0] inst_funct7 = '0;
  logic       take_branch = 1'b0;
  logic       inst_mem_ready = 1'b0;
  logic       data_mem_ready = 1'b0;
  logic       alu_done = 1'b0;

  logic       imre, irwe, pcwe, rfwe, asel_a, asel_b, astart, dmre, dmwe, retired, ill, bus, halt;
  logic [1:0] alu_op, npc;
  logic [2:0] wb;
  logic       nm_imre, nm_irwe, nm_pcwe, nm_rfwe, nm_asel_a, nm_asel_b, nm_astart;
  logic       nm_dmre, nm_dmwe, nm_retired, nm_ill, nm_bus, nm_halt;
  logic [1:0] nm_alu_op, nm_npc;
  logic [2:0] nm_wb;

  always #5 clock = ~clock;

  multicycle_control #(.MEM_TIMEOUT(4), .ENABLE_MULDIV(1)) dut (
    .clock(clock), .reset_n(reset_n), .inst_opcode(inst_opcode), .inst_funct7(inst_funct7),
    .take_branch(take_branch), .inst_mem_ready(inst_mem_ready), .data_mem_ready(data_mem_ready),
    .alu_done(alu_done), .inst_mem_read_enable(imre), .ir_write_enable(irwe),
    .pc_write_enable(pcwe), .regfile_write_enable(rfwe), .alu_operand_a_select(asel_a),
    .alu_operand_b_select(asel_b), .alu_op_type(alu_op), .alu_start(astart),
    .data_mem_read_enable(dmre), .data_mem_write_enable(dmwe), .reg_writeback_select(wb),
    .next_pc_select(npc), .inst_retired(retired), .illegal_inst(ill), .bus_error(bus),
    .halted(halt)
  );

  multicycle_control #(.MEM_TIMEOUT(4), .ENABLE_MULDIV(0)) dut_nm (
    .clock(clock), .reset_n(reset_n), .inst_opcode(inst_opcode), .inst_funct7(inst_funct7),
    .take_branch(take_branch), .inst_mem_ready(inst_mem_ready), .data_mem_ready(data_mem_ready),
    .alu_done(alu_done), .inst_mem_read_enable(nm_imre), .ir_write_enable(nm_irwe),
    .pc_write_enable(nm_pcwe), .regfile_write_enable(nm_rfwe), .alu_operand_a_select(nm_asel_a),
    .alu_operand_b_select(nm_asel_b), .alu_op_type(nm_alu_op), .alu_start(nm_astart),
    .data_mem_read_enable(nm_dmre), .data_mem_write_enable(nm_dmwe), .reg_writeback_select(nm_wb),
    .next_pc_select(nm_npc), .inst_retired(nm_retired), .illegal_inst(nm_ill), .bus_error(nm_bus),
    .halted(nm_halt)
  );

  localparam logic [10:0] EN_IMRE = 11'h400;
  localparam logic [10:0] EN_IRWE = 11'h200;
  localparam logic [10:0] EN_PCWE = 11'h100;
  localparam logic [10:0] EN_RFWE = 11'h080;
  localparam logic [10:0] EN_RET  = 11'h040;
  localparam logic [10:0] EN_DMRE = 11'h020;
  localparam logic [10:0] EN_DMWE = 11'h010;
  localparam logic [10:0] EN_ASTART = 11'h008;
  localparam logic [10:0] EN_HALT = 11'h004;
  localparam logic [10:0] EN_ILL  = 11'h002;
  localparam logic [10:0] EN_BUS  = 11'h001;
  localparam logic [10:0] EN_NONE = 11'h000;
  localparam logic [10:0] EN_COMMIT = EN_PCWE | EN_RET;
  localparam logic [10:0] EN_WB = EN_PCWE | EN_RFWE | EN_RET;
  localparam logic [10:0] EN_FETCHED = EN_IMRE | EN_IRWE;

  logic [10:0] en_vec, nm_en_vec;
  logic [8:0]  sel_vec, nm_sel_vec;
  assign en_vec     = {imre, irwe, pcwe, rfwe, retired, dmre, dmwe, astart, halt, ill, bus};
  assign sel_vec    = {asel_a, asel_b, alu_op, wb, npc};
  assign nm_en_vec  = {nm_imre, nm_irwe, nm_pcwe, nm_rfwe, nm_retired, nm_dmre, nm_dmwe,
                       nm_astart, nm_halt, nm_ill, nm_bus};
  assign nm_sel_vec = {nm_asel_a, nm_asel_b, nm_alu_op, nm_wb, nm_npc};

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] sv(input logic a, input logic b, input logic [1:0] op,
                                    input logic [2:0] wbs, input logic [1:0] nps);
    return {a, b, op, wbs, nps};
  endfunction

  // Called #1 after a rising edge with the cycle's inputs already applied.
  task automatic cyc(input string tag, input logic [10:0] exp_en, input logic [8:0] exp_sel);
    @(negedge clock);
    check_eq({tag, ".en"}, 32'(en_vec), 32'(exp_en));
    check_eq({tag, ".sel"}, 32'(sel_vec), 32'(exp_sel));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    inst_mem_ready = 1'b0;
    data_mem_ready = 1'b0;
    alu_done = 1'b0;
    take_branch = 1'b0;
    inst_funct7 = '0;
    reset_n = 1'b0;
    #1;
    check_eq({tag, ".rst_en"}, 32'(en_vec), 32'(EN_IMRE));
    check_eq({tag, ".rst_sel"}, 32'(sel_vec), 32'(9'd0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    $display("reset applied during %s", tag);
  endtask

  task automatic run_simple(input string name, input logic [6:0] opc, input logic take,
                            input logic commit_in_exec, input logic [8:0] exec_sel,
                            input logic [8:0] wb_sel);
    inst_opcode = opc;
    inst_funct7 = '0;
    take_branch = take;
    inst_mem_ready = 1'b1;
    cyc({name, ".fetch"}, EN_FETCHED, 9'd0);
    inst_mem_ready = 1'b0;
    cyc({name, ".decode"}, EN_NONE, 9'd0);
    if (commit_in_exec) begin
      cyc({name, ".exec"}, EN_COMMIT, exec_sel);
    end else begin
      cyc({name, ".exec"}, EN_NONE, exec_sel);
      cyc({name, ".wb"}, EN_WB, wb_sel);
    end
    $display("instruction %s sequenced", name);
  endtask

  initial begin
    @(posedge clock);
    #1;
    do_reset("power_on");

    run_simple("add",   OPCODE_OP,     1'b0, 1'b0, sv(ALU_A_RS1, ALU_B_RS2, ALU_OP, 3'd0, 2'd0), 9'd0);
    run_simple("addi",  OPCODE_OP_IMM, 1'b0, 1'b0, sv(ALU_A_RS1, ALU_B_IMM, ALU_OP_IMM, 3'd0, 2'd0), 9'd0);
    run_simple("lui",   OPCODE_LUI,    1'b0, 1'b0, 9'd0, sv(1'b0, 1'b0, 2'd0, WRITEBACK_IMM, NEXT_PC_PC4));
    run_simple("auipc", OPCODE_AUIPC,  1'b0, 1'b0, sv(ALU_A_PC, ALU_B_IMM, ALU_ADD, 3'd0, 2'd0), 9'd0);
    run_simple("jal",   OPCODE_JAL,    1'b0, 1'b0, sv(ALU_A_PC, ALU_B_IMM, ALU_ADD, 3'd0, 2'd0),
               sv(1'b0, 1'b0, 2'd0, WRITEBACK_PC4, NEXT_PC_PC_IMM));
    run_simple("jalr",  OPCODE_JALR,   1'b0, 1'b0, sv(ALU_A_RS1, ALU_B_IMM, ALU_ADD, 3'd0, 2'd0),
               sv(1'b0, 1'b0, 2'd0, WRITEBACK_PC4, NEXT_PC_RS1_IMM));
    run_simple("beq_taken", OPCODE_BRANCH, 1'b1, 1'b1,
               sv(ALU_A_RS1, ALU_B_RS2, ALU_BRANCH, 3'd0, NEXT_PC_PC_IMM), 9'd0);
    run_simple("bne_not_taken", OPCODE_BRANCH, 1'b0, 1'b1,
               sv(ALU_A_RS1, ALU_B_RS2, ALU_BRANCH, 3'd0, NEXT_PC_PC4), 9'd0);
    run_simple("fence", OPCODE_MISC_MEM, 1'b0, 1'b1, 9'd0, 9'd0);
    take_branch = 1'b0;

    // LOAD, data ready on the fourth MEM cycle; data ready early is ignored.
    inst_opcode = OPCODE_LOAD;
    inst_mem_ready = 1'b1;
    data_mem_ready = 1'b1;
    cyc("lw.fetch", EN_FETCHED, 9'd0);
    inst_mem_ready = 1'b0;
    cyc("lw.decode", EN_NONE, 9'd0);
    cyc("lw.exec", EN_NONE, sv(ALU_A_RS1, ALU_B_IMM, ALU_ADD, 3'd0, 2'd0));
    data_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("lw.mem_wait%0d", i), EN_DMRE, 9'd0);
    data_mem_ready = 1'b1;
    cyc("lw.mem_ready", EN_DMRE, 9'd0);
    data_mem_ready = 1'b0;
    cyc("lw.wb", EN_WB, sv(1'b0, 1'b0, 2'd0, WRITEBACK_DATA, NEXT_PC_PC4));
    $display("instruction lw sequenced");

    // STORE with zero-wait data memory commits in the MEM cycle.
    inst_opcode = OPCODE_STORE;
    inst_mem_ready = 1'b1;
    cyc("sw.fetch", EN_FETCHED, 9'd0);
    inst_mem_ready = 1'b0;
    cyc("sw.decode", EN_NONE, 9'd0);
    cyc("sw.exec", EN_NONE, sv(ALU_A_RS1, ALU_B_IMM, ALU_ADD, 3'd0, 2'd0));
    data_mem_ready = 1'b1;
    cyc("sw.mem", EN_DMWE | EN_COMMIT, 9'd0);
    data_mem_ready = 1'b0;
    $display("instruction sw sequenced");

    // STORE whose data memory never answers.
    inst_mem_ready = 1'b1;
    cyc("sw_to.fetch", EN_FETCHED, 9'd0);
    inst_mem_ready = 1'b0;
    cyc("sw_to.decode", EN_NONE, 9'd0);
    cyc("sw_to.exec", EN_NONE, sv(ALU_A_RS1, ALU_B_IMM, ALU_ADD, 3'd0, 2'd0));
    for (int i = 0; i < 5; i++) cyc($sformatf("sw_to.wait%0d", i), EN_DMWE, 9'd0);
    cyc("sw_to.trap", EN_HALT | EN_BUS, 9'd0);
    inst_mem_ready = 1'b1;
    data_mem_ready = 1'b1;
    cyc("sw_to.trap_hold", EN_HALT | EN_BUS, 9'd0);
    do_reset("sw_timeout_trap");

    // Fetch timeout: ready never comes.
    inst_opcode = OPCODE_OP;
    for (int i = 0; i < 5; i++) cyc($sformatf("if_to.wait%0d", i), EN_IMRE, 9'd0);
    cyc("if_to.trap", EN_HALT | EN_BUS, 9'd0);
    cyc("if_to.trap_hold", EN_HALT | EN_BUS, 9'd0);
    do_reset("fetch_timeout_trap");

    // Ready in the same cycle the count reaches the limit wins.
    for (int i = 0; i < 4; i++) cyc($sformatf("if_late.wait%0d", i), EN_IMRE, 9'd0);
    inst_mem_ready = 1'b1;
    cyc("if_late.ready", EN_FETCHED, 9'd0);
    inst_mem_ready = 1'b0;
    cyc("if_late.decode", EN_NONE, 9'd0);
    cyc("if_late.exec", EN_NONE, sv(ALU_A_RS1, ALU_B_RS2, ALU_OP, 3'd0, 2'd0));
    cyc("if_late.wb", EN_WB, 9'd0);
    $display("instruction add after late fetch sequenced");

    // Illegal opcode.
    inst_opcode = 7'b0000000;
    inst_mem_ready = 1'b1;
    cyc("illegal.fetch", EN_FETCHED, 9'd0);
    inst_mem_ready = 1'b0;
    cyc("illegal.decode", EN_NONE, 9'd0);
    cyc("illegal.trap", EN_HALT | EN_ILL, 9'd0);
    do_reset("illegal_trap");

    // M op: waits for alu_done on the M-enabled instance, traps on the other.
    inst_opcode = OPCODE_OP;
    inst_funct7 = FUNCT7_MULDIV;
    inst_mem_ready = 1'b1;
    cyc("mul.fetch", EN_FETCHED, 9'd0);
    inst_mem_ready = 1'b0;
    cyc("mul.decode", EN_NONE, 9'd0);
    check_eq("mul_nomuldiv.en", 32'(nm_en_vec), 32'(EN_HALT | EN_ILL));
    check_eq("mul_nomuldiv.sel", 32'(nm_sel_vec), 32'(9'd0));
    cyc("mul.start", EN_ASTART, sv(ALU_A_RS1, ALU_B_RS2, ALU_OP, 3'd0, 2'd0));
    for (int i = 0; i < 4; i++)
      cyc($sformatf("mul.busy%0d", i), EN_NONE, sv(ALU_A_RS1, ALU_B_RS2, ALU_OP, 3'd0, 2'd0));
    alu_done = 1'b1;
    cyc("mul.done", EN_NONE, sv(ALU_A_RS1, ALU_B_RS2, ALU_OP, 3'd0, 2'd0));
    alu_done = 1'b0;
    cyc("mul.wb", EN_WB, 9'd0);
    $display("instruction mul sequenced");
    do_reset("after_mul");

    // Reset in the middle of a data memory wait.
    inst_opcode = OPCODE_LOAD;
    inst_mem_ready = 1'b1;
    cyc("lw_rst.fetch", EN_FETCHED, 9'd0);
    inst_mem_ready = 1'b0;
    cyc("lw_rst.decode", EN_NONE, 9'd0);
    cyc("lw_rst.exec", EN_NONE, sv(ALU_A_RS1, ALU_B_IMM, ALU_ADD, 3'd0, 2'd0));
    cyc("lw_rst.wait0", EN_DMRE, 9'd0);
    cyc("lw_rst.wait1", EN_DMRE, 9'd0);
    do_reset("mem_wait");
    run_simple("add_after_reset", OPCODE_OP, 1'b0, 1'b0,
               sv(ALU_A_RS1, ALU_B_RS2, ALU_OP, 3'd0, 2'd0), 9'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
